timer_arbiter: RTL and testbench
================================

Name: timer_arbiter

Overview:
- Shares one terminal-count timer among N requesters.
- Each requester asks for a timed interval of its own length. The block grants the timer round-robin, runs it, and returns a one-cycle done pulse to the winner.
- Sits between multiple control FSMs and the single counter resource, so each FSM does not need its own timer instance.

Parameters:
N, 4, number of requesters (2..8)
WIDTH, 8, bit width of period and count

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-low (0 = reset)
req  input  N  request, one bit per requester; held high until done or abort
period  input  N*WIDTH  requested terminal value; requester i uses bits [i*WIDTH +: WIDTH]
grant  output  N  one-hot registered grant; all-zero when timer is free
done  output  N  one-cycle pulse to the requester whose interval completed
busy  output  1  high while timer is counting (state COUNT)
count  output  WIDTH  current timer value

Behaviour:
- Reset (rst low, asynchronous): state=IDLE, grant=0, done=0, busy=0, count=0, rr pointer=0. Effect is immediate, not on the next edge. Reset mid-interval discards it, with no done pulse.
- States: IDLE, COUNT, DONE.
- IDLE:
  - If any req bit is set, select the first set bit scanning from the pointer upward, wrapping modulo N.
  - Next edge: grant[g]=1, period_q latched from that requester's period slice, count=0, busy=1, state=COUNT.
  - No requests: stay in IDLE, all outputs low/zero.
- COUNT:
  - count increments by 1 each edge.
  - Terminal condition: count == period_q. Next edge: state=DONE, done[g]=1, grant=0, busy=0, count=0, pointer=(g+1) mod N.
  - Period input changes during COUNT are ignored (latched value rules).
- DONE: lasts exactly one cycle with done[g] high, then unconditionally IDLE; done clears.
- Latency: grant rises at edge t0; done rises at edge t0+period_q+1. period_q=0 gives done one cycle after grant.
- count never exceeds period_q and never wraps. period_q = 2^WIDTH-1 is legal; terminal at all-ones.
- Abort:
  - If req[g] is low during COUNT, the next edge goes to IDLE: grant=0, busy=0, count=0, pointer=(g+1) mod N, no done.
  - Abort and terminal on the same cycle: abort wins, no done.
- Requests from non-granted requesters are ignored (not queued) while COUNT/DONE; they are re-evaluated in IDLE.
- A requester still holding req during its DONE cycle is treated as a fresh request. Round-robin makes it lowest priority.
- Minimum turnaround between consecutive grants: 2 cycles (DONE + IDLE).
- All outputs are registered; no combinational path from req to grant/done.

Test Plan:
1. Single requester: N=4, WIDTH=8, req[0]=1, period0=3 -> grant=0001 one edge after req seen in IDLE; count 0,1,2,3; done=0001 for exactly one cycle 4 cycles after grant rise; grant=0 in the same cycle.
2. Simultaneous requests after reset: req=1111, all periods=1 -> grants in order 0001,0010,0100,1000. Each grant lasts 2 cycles; each is followed by a done pulse to the same index.
3. Fairness: req[0] and req[2] held high continuously, periods=2 -> grant alternates 0001,0100,0001,0100, never two consecutive to the same index.
4. Boundaries:
   - period=0 -> done one cycle after grant, count stays 0.
   - period=255 -> done 256 cycles after grant, count max 255, no wrap.
   - Changing period mid-COUNT does not alter timing.
5. Abort: req[1] granted with period=10, drop req[1] when count=2 -> next edge grant=0, count=0, no done[1]. If req[2] is pending, grant=0100 one cycle later.
6. Async reset: assert rst low between clock edges with count=5 -> grant, done, busy and count are zero before the next edge. After release, req[3] alone is granted first, with the pointer back at 0 but no other requesters pending.

Source files
------------

// File: rtl/timer_arbiter.sv
// timer_arbiter: shares one terminal-count timer among N requesters.
// Grants are round-robin. The winner's period is captured when the grant is
// issued, the shared counter runs up to that value, and the winner then gets a
// one-cycle done pulse. If the winner drops its request while the timer is
// counting, the interval is aborted and no done pulse is sent.
module timer_arbiter #(
  parameter int unsigned N     = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N-1:0]       req,
  input  logic [N*WIDTH-1:0] period,
  output logic [N-1:0]       grant,
  output logic [N-1:0]       done,
  output logic               busy,
  output logic [WIDTH-1:0]   count
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COUNT,
    S_DONE
  } state_e;

  state_e           state_q,  state_d;
  logic [N-1:0]     grant_q,  grant_d;
  logic [N-1:0]     done_q,   done_d;
  logic             busy_q,   busy_d;
  logic [WIDTH-1:0] count_q,  count_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic [PW-1:0]    ptr_q,    ptr_d;
  logic [PW-1:0]    owner_q,  owner_d;

  logic             pick_valid;
  logic [PW-1:0]    pick_idx;
  logic [PW-1:0]    ptr_after_owner;
  int unsigned      scan_idx;

  // Round-robin pick: first set request scanning upward from the pointer, wrapping
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    scan_idx   = 0;
    for (int unsigned i = 0; i < N; i++) begin
      scan_idx = (32'(ptr_q) + i) % N;
      if (!pick_valid && req[scan_idx]) begin
        pick_valid = 1'b1;
        pick_idx   = PW'(scan_idx);
      end
    end
  end

  // Pointer value used after the current owner finishes or aborts
  always_comb begin
    ptr_after_owner = PW'((32'(owner_q) + 32'd1) % N);
  end

  // Next-state and registered-output computation
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    done_d   = '0;
    busy_d   = busy_q;
    count_d  = count_q;
    period_d = period_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;

    unique case (state_q)
      S_IDLE: begin
        grant_d = '0;
        busy_d  = 1'b0;
        count_d = '0;
        if (pick_valid) begin
          state_d  = S_COUNT;
          grant_d  = {{(N-1){1'b0}}, 1'b1} << pick_idx;
          owner_d  = pick_idx;
          period_d = period[pick_idx*WIDTH +: WIDTH];
          busy_d   = 1'b1;
        end
      end

      S_COUNT: begin
        // An abort is checked before the terminal count so that it takes
        // priority when both happen in the same cycle.
        if (!req[owner_q]) begin
          state_d = S_IDLE;
          grant_d = '0;
          busy_d  = 1'b0;
          count_d = '0;
          ptr_d   = ptr_after_owner;
        end else if (count_q == period_q) begin
          state_d = S_DONE;
          done_d  = grant_q;
          grant_d = '0;
          busy_d  = 1'b0;
          count_d = '0;
          ptr_d   = ptr_after_owner;
        end else begin
          count_d = count_q + 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
        count_d = '0;
      end

      default: begin
        state_d = S_IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
        count_d = '0;
      end
    endcase
  end

  // State and output registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      grant_q  <= '0;
      done_q   <= '0;
      busy_q   <= 1'b0;
      count_q  <= '0;
      period_q <= '0;
      ptr_q    <= '0;
      owner_q  <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      count_q  <= count_d;
      period_q <= period_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
    end
  end

  assign grant = grant_q;
  assign done  = done_q;
  assign busy  = busy_q;
  assign count = count_q;

endmodule

// File: tb/tb_timer_arbiter.sv
// Testbench for timer_arbiter: scenario tasks compare the DUT against
// explicit expectations or against an interval schedule derived from the
// round-robin and timing rules.
module tb_timer_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] period = '0;
  logic [N-1:0]   grant;
  logic [N-1:0]   done;
  logic           busy;
  logic [W-1:0]   count;

  int passed = 0;
  int total  = 0;

  timer_arbiter #(.N(N), .WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .period (period),
    .grant  (grant),
    .done   (done),
    .busy   (busy),
    .count  (count)
  );

  always #5 clk = ~clk;

  // Reference model: a list of granted intervals. The owner holds the grant
  // for sample indices g..d-1 (count = k-g) and gets done at sample d. The
  // next grant comes two samples after d, from the next requester in
  // round-robin order.
  typedef struct {
    int owner;
    int g;
    int d;
  } seg_t;

  seg_t sched[$];
  int   per_m[N];

  function automatic void build_schedule(input logic [N-1:0] mask, input int n);
    int ptr = 0;
    int t   = 1;
    int owner;
    sched.delete();
    for (int j = 0; j < n; j++) begin
      owner = -1;
      for (int i = 0; i < N; i++) begin
        if (owner < 0 && mask[(ptr + i) % N]) owner = (ptr + i) % N;
      end
      sched.push_back('{owner: owner, g: t, d: t + per_m[owner] + 1});
      t   = t + per_m[owner] + 3;
      ptr = (owner + 1) % N;
    end
  endfunction

  function automatic void expect_at(input int k, output logic [N-1:0] eg,
                                    output logic [N-1:0] ed, output logic eb,
                                    output logic [W-1:0] ec);
    eg = '0; ed = '0; eb = 1'b0; ec = '0;
    foreach (sched[j]) begin
      if (k >= sched[j].g && k < sched[j].d) begin
        eg[sched[j].owner] = 1'b1;
        eb = 1'b1;
        ec = W'(k - sched[j].g);
      end else if (k == sched[j].d) begin
        ed[sched[j].owner] = 1'b1;
      end
    end
  endfunction

  task automatic set_period(input int i, input int v);
    period[i*W +: W] = W'(v);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1;
    total++; if (grant !== '0) $display("FAIL reset_grant: got %b want 0", grant); else passed++;
    total++; if (done !== '0) $display("FAIL reset_done: got %b want 0", done); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
    total++; if (count !== '0) $display("FAIL reset_count: got %0d want 0", count); else passed++;
  endtask

  task automatic test_single();
    logic [N-1:0] eg, ed;
    logic eb;
    logic [W-1:0] ec;
    do_reset();
    set_period(0, 3);
    req = 4'b0001;
    for (int k = 1; k <= 6; k++) begin
      step();
      eg = (k <= 4) ? 4'b0001 : 4'b0000;
      ed = (k == 5) ? 4'b0001 : 4'b0000;
      eb = (k <= 4);
      ec = (k <= 4) ? W'(k - 1) : '0;
      if (k == 5) req = '0;
      total++; if (grant !== eg) $display("FAIL single_grant k=%0d: got %b want %b", k, grant, eg); else passed++;
      total++; if (done !== ed) $display("FAIL single_done k=%0d: got %b want %b", k, done, ed); else passed++;
      total++; if (busy !== eb) $display("FAIL single_busy k=%0d: got %b want %b", k, busy, eb); else passed++;
      total++; if (count !== ec) $display("FAIL single_count k=%0d: got %0d want %0d", k, count, ec); else passed++;
    end
  endtask

  // Config 0: all four requesting with period 1; config 1: fairness between
  // 0 and 2 with period 2; the rest are random masks and periods, with the
  // owner's period input scrambled mid-interval.
  task automatic test_schedules();
    logic [N-1:0] mask, eg, ed;
    logic eb;
    logic [W-1:0] ec;
    int n, last, own;
    for (int cfg = 0; cfg < 10; cfg++) begin
      if (cfg == 0) begin
        mask = 4'b1111; n = 4;
        for (int i = 0; i < N; i++) per_m[i] = 1;
      end else if (cfg == 1) begin
        mask = 4'b0101; n = 4;
        for (int i = 0; i < N; i++) per_m[i] = 2;
      end else begin
        mask = N'($urandom_range(1, 15)); n = $urandom_range(3, 8);
        for (int i = 0; i < N; i++) per_m[i] = $urandom_range(0, 12);
      end
      build_schedule(mask, n);
      last = sched[sched.size()-1].d;
      do_reset();
      for (int i = 0; i < N; i++) set_period(i, per_m[i]);
      req = mask;
      for (int k = 1; k <= last + 1; k++) begin
        step();
        expect_at(k, eg, ed, eb, ec);
        total++; if (grant !== eg) $display("FAIL sched%0d_grant k=%0d: got %b want %b", cfg, k, grant, eg); else passed++;
        total++; if (done !== ed) $display("FAIL sched%0d_done k=%0d: got %b want %b", cfg, k, done, ed); else passed++;
        total++; if (busy !== eb) $display("FAIL sched%0d_busy k=%0d: got %b want %b", cfg, k, busy, eb); else passed++;
        total++; if (count !== ec) $display("FAIL sched%0d_count k=%0d: got %0d want %0d", cfg, k, count, ec); else passed++;
        if (cfg >= 2 && eb && ec != 0) begin
          own = 0;
          for (int i = 0; i < N; i++) if (eg[i]) own = i;
          set_period(own, $urandom_range(0, 255));
        end
        for (int i = 0; i < N; i++) if (ed[i]) set_period(i, per_m[i]);
        if (k == last) req = '0;
      end
    end
  endtask

  task automatic test_boundaries();
    // period 0: done on the sample right after the grant
    do_reset();
    set_period(0, 0);
    req = 4'b0001;
    step();
    total++; if (grant !== 4'b0001) $display("FAIL p0_grant: got %b want 0001", grant); else passed++;
    total++; if (count !== '0) $display("FAIL p0_count: got %0d want 0", count); else passed++;
    step();
    req = '0;
    total++; if (done !== 4'b0001) $display("FAIL p0_done: got %b want 0001", done); else passed++;
    total++; if (grant !== '0) $display("FAIL p0_grant_clear: got %b want 0", grant); else passed++;
    total++; if (count !== '0) $display("FAIL p0_count_after: got %0d want 0", count); else passed++;
    // period 255 with the period input changed mid-count
    do_reset();
    set_period(0, 255);
    req = 4'b0001;
    for (int k = 1; k <= 256; k++) begin
      step();
      if (k == 50) set_period(0, 5);
      total++; if (count !== W'(k - 1)) $display("FAIL p255_count k=%0d: got %0d want %0d", k, count, k - 1); else passed++;
      total++; if (done !== '0) $display("FAIL p255_early_done k=%0d: got %b want 0", k, done); else passed++;
    end
    step();
    req = '0;
    total++; if (done !== 4'b0001) $display("FAIL p255_done: got %b want 0001", done); else passed++;
    total++; if (count !== '0) $display("FAIL p255_count_end: got %0d want 0", count); else passed++;
  endtask

  task automatic test_abort();
    logic [N-1:0] eg, ed;
    logic eb;
    logic [W-1:0] ec;
    do_reset();
    set_period(1, 10);
    set_period(2, 3);
    req = 4'b0110;
    for (int k = 1; k <= 10; k++) begin
      step();
      eg = '0; ed = '0; eb = 1'b0; ec = '0;
      if (k <= 3) begin
        eg = 4'b0010; eb = 1'b1; ec = W'(k - 1);
      end else if (k >= 5 && k <= 8) begin
        eg = 4'b0100; eb = 1'b1; ec = W'(k - 5);
      end else if (k == 9) begin
        ed = 4'b0100;
      end
      if (k == 3) req[1] = 1'b0;
      if (k == 9) req = '0;
      total++; if (grant !== eg) $display("FAIL abort_grant k=%0d: got %b want %b", k, grant, eg); else passed++;
      total++; if (done !== ed) $display("FAIL abort_done k=%0d: got %b want %b", k, done, ed); else passed++;
      total++; if (busy !== eb) $display("FAIL abort_busy k=%0d: got %b want %b", k, busy, eb); else passed++;
      total++; if (count !== ec) $display("FAIL abort_count k=%0d: got %0d want %0d", k, count, ec); else passed++;
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    set_period(0, 2);
    set_period(1, 0);
    set_period(2, 20);
    req = 4'b0010;
    step();
    step();
    total++; if (done !== 4'b0010) $display("FAIL ar_first_done: got %b want 0010", done); else passed++;
    req = 4'b0100;
    repeat (7) step();
    total++; if (count !== 8'd5) $display("FAIL ar_pre_count: got %0d want 5", count); else passed++;
    #2 rst = 1'b0;
    #1;
    total++; if (grant !== '0) $display("FAIL ar_grant: got %b want 0", grant); else passed++;
    total++; if (done !== '0) $display("FAIL ar_done: got %b want 0", done); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL ar_busy: got %b want 0", busy); else passed++;
    total++; if (count !== '0) $display("FAIL ar_count: got %0d want 0", count); else passed++;
    @(negedge clk);
    req = 4'b1001;
    rst = 1'b1;
    step();
    total++; if (grant !== 4'b0001) $display("FAIL ar_ptr_reset: got %b want 0001", grant); else passed++;
    total++; if (done !== '0) $display("FAIL ar_no_done: got %b want 0", done); else passed++;
    do_reset();
    req = 4'b1000;
    step();
    total++; if (grant !== 4'b1000) $display("FAIL ar_req3_alone: got %b want 1000", grant); else passed++;
    req = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_schedules();
    test_boundaries();
    test_abort();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
